div_unit: RTL

- Iterative 32-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits directly downstream of registerFile32 and consumes rd1/rd2 as operands.
- Produces a one-cycle writeback (address, data, write enable) that feeds registerFile32 a3/di3/we3 through the writeback mux.
- Stalls the pipeline through busy while a division is in flight.

---
 rtl/div_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor skips straight to the writeback.
module div_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wb_a3,
    output logic [WIDTH-1:0]  wb_di3,
    output logic              wb_we3
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]  quo, rem, dvs, a_orig;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] rd_q;
    logic              sel_rem, q_neg, r_neg, dz;

    logic              sgn_in, a_neg_in, b_neg_in, dz_now;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH-1:0]  rem_nx, q_fix, r_fix;
    logic              ge;

    assign sgn_in   = !op[0];
    assign a_neg_in = sgn_in && rs1_data[WIDTH-1];
    assign b_neg_in = sgn_in && rs2_data[WIDTH-1];
    assign a_mag    = a_neg_in ? -rs1_data : rs1_data;
    assign b_mag    = b_neg_in ? -rs2_data : rs2_data;
    assign dz_now   = (rs2_data == '0);

    // The compare keeps the shifted-out bit, so the borrow is never lost.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, dvs});
    assign rem_nx = rem_sh[WIDTH-1:0] - dvs;

    assign q_fix = dz ? '1 : (q_neg ? -quo : quo);
    assign r_fix = dz ? a_orig : (r_neg ? -rem : rem);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_SHORTCUT_EN
                    state_n = dz_now ? DONE : CALC;
`else
                    state_n = CALC;
`endif
                end
            end
            CALC:    if (cnt == '0) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            a_orig  <= '0;
            cnt     <= '0;
            rd_q    <= '0;
            sel_rem <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
            wb_a3   <= '0;
            wb_di3  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= a_mag;
                        rem     <= '0;
                        dvs     <= b_mag;
                        a_orig  <= rs1_data;
                        cnt     <= CW'(WIDTH - 1);
                        rd_q    <= rd_addr;
                        sel_rem <= op[1];
                        q_neg   <= a_neg_in ^ b_neg_in;
                        r_neg   <= a_neg_in;
                        dz      <= dz_now;
`ifdef DIV_ZERO_SHORTCUT_EN
                        if (dz_now) begin
                            wb_di3 <= op[1] ? rs1_data : '1;
                            wb_a3  <= rd_addr;
                        end
`endif
                    end
                end
                CALC: begin
                    rem <= ge ? rem_nx : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    wb_di3 <= sel_rem ? r_fix : q_fix;
                    wb_a3  <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign wb_we3 = done && (wb_a3 != '0);

endmodule
